// File: rtl/instr_mem_responder_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
// Optional parity storage is enabled elsewhere by defining INSTR_MEM_PARITY_EN.
package pipe_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch-side request/response handshake between the fetch stage (master)
// and the instruction-memory responder (slave).
interface instr_mem_responder_if #(
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int DATA_W = pipe_pkg::DATA_W
) ();

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr
    );

endinterface

// File: rtl/instr_mem_responder_array.sv
// Program store: one write port, one registered read port, per-word written bits.
// INSTR_MEM_PARITY_EN adds a stored even-parity bit per word and a read-time check.
module instr_mem_array #(
    parameter int                ADDR_W   = pipe_pkg::ADDR_W,
    parameter int                DATA_W   = pipe_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_WORD = pipe_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef INSTR_MEM_PARITY_EN
    output logic              rd_perr,
`endif
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    // Storage is deliberately not reset; the written bits make stale contents invisible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                written[wr_addr] <= 1'b1;
            end
            if (rd_en) begin
                rd_data <= written[rd_addr] ? mem[rd_addr] : NOP_WORD;
            end
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par[wr_addr] <= ^wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_perr <= 1'b0;
        end else if (rd_en) begin
            rd_perr <= written[rd_addr] && ((^mem[rd_addr]) != par[rd_addr]);
        end
    end
`endif

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: sequential program loader plus 1-cycle-latency fetch port.
// Define INSTR_MEM_PARITY_EN to add per-word parity storage and the parity_err output.
module instr_mem_responder #(
    parameter int                ADDR_W   = pipe_pkg::ADDR_W,
    parameter int                DATA_W   = pipe_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_WORD = pipe_pkg::NOP_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 load_wr,
    input  logic [DATA_W-1:0]    load_data,
    input  logic                 load_done,
    output logic [ADDR_W-1:0]    load_ptr,
    output logic                 loading,
`ifdef INSTR_MEM_PARITY_EN
    output logic                 parity_err,
`endif
    instr_mem_responder_if.slave fetch
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    pipe_pkg::imem_state_e state, state_next;
    logic [ADDR_W-1:0]     ptr_next;
    logic                  rsp_valid_q, rsp_valid_next;
    logic                  req_ready_c;
    logic                  wr_en, rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= pipe_pkg::IMEM_LOAD;
            load_ptr    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            load_ptr    <= ptr_next;
            rsp_valid_q <= rsp_valid_next;
        end
    end

    always_comb begin
        state_next     = state;
        ptr_next       = load_ptr;
        rsp_valid_next = rsp_valid_q;
        req_ready_c    = 1'b0;
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        case (state)
            pipe_pkg::IMEM_LOAD: begin
                if (load_start) begin
                    ptr_next = '0;
                end else if (load_wr) begin
                    wr_en    = 1'b1;
                    ptr_next = load_ptr + 1'b1;
                    if (load_ptr == LAST_ADDR) begin
                        state_next = pipe_pkg::IMEM_RUN;
                    end
                end
                if (load_done) begin
                    state_next = pipe_pkg::IMEM_RUN;
                end
            end
            pipe_pkg::IMEM_RUN: begin
                if (load_start) begin
                    // Reload request wins: pending response is dropped, nothing accepted.
                    state_next     = pipe_pkg::IMEM_LOAD;
                    ptr_next       = '0;
                    rsp_valid_next = 1'b0;
                end else begin
                    req_ready_c = !rsp_valid_q || fetch.rsp_ready;
                    if (fetch.req_valid && req_ready_c) begin
                        rd_en          = 1'b1;
                        rsp_valid_next = 1'b1;
                    end else if (fetch.rsp_ready) begin
                        rsp_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = pipe_pkg::IMEM_LOAD;
            end
        endcase
    end

    assign loading         = (state == pipe_pkg::IMEM_LOAD);
    assign fetch.req_ready = req_ready_c;
    assign fetch.rsp_valid = rsp_valid_q;

    instr_mem_array #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_WORD (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (load_ptr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (fetch.req_addr),
`ifdef INSTR_MEM_PARITY_EN
        .rd_perr (parity_err),
`endif
        .rd_data (fetch.rsp_instr)
    );

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: reference model of the program store,
// expected fetch responses queued at request acceptance and compared on arrival.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_wr;
    logic [15:0] load_data;
    logic        load_done;
    logic [7:0]  load_ptr;
    logic        loading;
`ifdef INSTR_MEM_PARITY_EN
    logic        parity_err;
`endif

    instr_mem_responder_if fetch ();

    instr_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_wr    (load_wr),
        .load_data  (load_data),
        .load_done  (load_done),
        .load_ptr   (load_ptr),
        .loading    (loading),
`ifdef INSTR_MEM_PARITY_EN
        .parity_err (parity_err),
`endif
        .fetch      (fetch)
    );

    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [15:0] model_mem [256];
    logic        model_wr  [256];
    logic [15:0] sb [$];
    logic        acc;
    logic [15:0] exp_w;

    function automatic logic [15:0] model_read(input logic [7:0] a);
        return model_wr[a] ? model_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] pop_exp();
        if (sb.size() == 0) return 16'hxxxx;
        return sb.pop_front();
    endfunction

    // Inputs change at negedge; acceptance is judged just before the rising edge.
    task automatic tick();
        #1;
        acc = fetch.req_valid && fetch.req_ready;
        @(posedge clk);
        if (acc) sb.push_back(model_read(fetch.req_addr));
        @(negedge clk);
    endtask

    task automatic drain();
        fetch.req_valid = 1'b0;
        fetch.rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_start = 1'b0; load_wr = 1'b0; load_done = 1'b0; load_data = '0;
        fetch.req_valid = 1'b0; fetch.req_addr = '0; fetch.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) model_wr[i] = 1'b0;
        tick(); tick();
        total_cnt++; if (loading !== 1'b1) $display("FAIL reset_loading: got %b want 1", loading); else pass_cnt++;
        total_cnt++; if (load_ptr !== 8'h00) $display("FAIL reset_load_ptr: got %h want 00", load_ptr); else pass_cnt++;
        total_cnt++; if (fetch.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", fetch.rsp_valid); else pass_cnt++;
        total_cnt++; if (fetch.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", fetch.req_ready); else pass_cnt++;
        total_cnt++; if (fetch.rsp_instr !== 16'h0000) $display("FAIL reset_rsp_instr: got %h want 0000", fetch.rsp_instr); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_basic();
        logic [15:0] words [3];
        words[0] = 16'hA001; words[1] = 16'hB002; words[2] = 16'hC003;
        for (int i = 0; i < 3; i++) begin
            load_wr = 1'b1; load_data = words[i];
            model_mem[i] = words[i]; model_wr[i] = 1'b1;
            tick();
        end
        load_wr = 1'b0;
        total_cnt++; if (loading !== 1'b1) $display("FAIL load_still_loading: got %b want 1", loading); else pass_cnt++;
        total_cnt++; if (fetch.req_ready !== 1'b0) $display("FAIL load_req_ready: got %b want 0", fetch.req_ready); else pass_cnt++;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        total_cnt++; if (load_ptr !== 8'h03) $display("FAIL load_done_ptr: got %h want 03", load_ptr); else pass_cnt++;
        total_cnt++; if (loading !== 1'b0) $display("FAIL load_done_loading: got %b want 0", loading); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        fetch.rsp_ready = 1'b1;
        fetch.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch.req_addr = 8'(i);
            tick();
            exp_w = pop_exp();
            total_cnt++;
            if (fetch.rsp_valid !== 1'b1 || fetch.rsp_instr !== exp_w)
                $display("FAIL b2b_rsp[%0d]: got valid=%b instr=%h want valid=1 instr=%h", i, fetch.rsp_valid, fetch.rsp_instr, exp_w);
            else pass_cnt++;
        end
        fetch.req_valid = 1'b0;
        tick();
        total_cnt++; if (fetch.rsp_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", fetch.rsp_valid); else pass_cnt++;
        total_cnt++; if (fetch.rsp_instr !== 16'hC003) $display("FAIL b2b_instr_hold: got %h want c003", fetch.rsp_instr); else pass_cnt++;
    endtask

    task automatic test_unwritten();
        fetch.rsp_ready = 1'b1;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'h50;
        tick();
        fetch.req_valid = 1'b0;
        exp_w = pop_exp();
        total_cnt++;
        if (fetch.rsp_valid !== 1'b1 || fetch.rsp_instr !== exp_w)
            $display("FAIL unwritten_rsp: got valid=%b instr=%h want valid=1 instr=%h", fetch.rsp_valid, fetch.rsp_instr, exp_w);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_backpressure();
        fetch.rsp_ready = 1'b1;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'h01;
        tick();
        exp_w = pop_exp();
        total_cnt++; if (fetch.rsp_instr !== exp_w) $display("FAIL bp_first: got %h want %h", fetch.rsp_instr, exp_w); else pass_cnt++;
        fetch.rsp_ready = 1'b0;
        fetch.req_addr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (fetch.req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", i, fetch.req_ready); else pass_cnt++;
            tick();
            total_cnt++;
            if (fetch.rsp_valid !== 1'b1 || fetch.rsp_instr !== 16'hB002)
                $display("FAIL bp_hold[%0d]: got valid=%b instr=%h want valid=1 instr=b002", i, fetch.rsp_valid, fetch.rsp_instr);
            else pass_cnt++;
        end
        fetch.rsp_ready = 1'b1;
        #1;
        total_cnt++; if (fetch.req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", fetch.req_ready); else pass_cnt++;
        tick();
        exp_w = pop_exp();
        total_cnt++;
        if (fetch.rsp_valid !== 1'b1 || fetch.rsp_instr !== exp_w)
            $display("FAIL bp_release_rsp: got valid=%b instr=%h want valid=1 instr=%h", fetch.rsp_valid, fetch.rsp_instr, exp_w);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_load_start_drop();
        fetch.rsp_ready = 1'b1;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'h00;
        tick();
        exp_w = pop_exp();
        total_cnt++; if (fetch.rsp_instr !== exp_w) $display("FAIL drop_pre_rsp: got %h want %h", fetch.rsp_instr, exp_w); else pass_cnt++;
        fetch.rsp_ready = 1'b0;
        load_start = 1'b1;
        #1;
        total_cnt++; if (fetch.req_ready !== 1'b0) $display("FAIL drop_req_ready: got %b want 0", fetch.req_ready); else pass_cnt++;
        tick();
        load_start = 1'b0;
        fetch.req_valid = 1'b0;
        total_cnt++; if (fetch.rsp_valid !== 1'b0) $display("FAIL drop_rsp_valid: got %b want 0", fetch.rsp_valid); else pass_cnt++;
        total_cnt++; if (loading !== 1'b1 || load_ptr !== 8'h00) $display("FAIL drop_reload: got loading=%b ptr=%h want loading=1 ptr=00", loading, load_ptr); else pass_cnt++;
    endtask

    task automatic test_auto_finish();
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            load_wr = 1'b1; load_data = {b, ~b};
            model_mem[i] = {b, ~b}; model_wr[i] = 1'b1;
            tick();
            if (i == 254) begin
                total_cnt++; if (loading !== 1'b1) $display("FAIL auto_before_last: got loading=%b want 1", loading); else pass_cnt++;
            end
        end
        load_wr = 1'b0;
        total_cnt++; if (loading !== 1'b0 || load_ptr !== 8'h00) $display("FAIL auto_finish: got loading=%b ptr=%h want loading=0 ptr=00", loading, load_ptr); else pass_cnt++;
        // Loader writes in RUN must not reach the store or move the pointer.
        load_wr = 1'b1; load_data = 16'hDEAD;
        tick();
        load_wr = 1'b0;
        total_cnt++; if (load_ptr !== 8'h00) $display("FAIL run_ignore_ptr: got %h want 00", load_ptr); else pass_cnt++;
        fetch.rsp_ready = 1'b1;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'hFF;
        tick();
        exp_w = pop_exp();
        total_cnt++; if (fetch.rsp_instr !== 16'hFF00 || exp_w !== 16'hFF00) $display("FAIL auto_last_word: got %h want ff00", fetch.rsp_instr); else pass_cnt++;
        fetch.req_addr = 8'h00;
        tick();
        exp_w = pop_exp();
        total_cnt++; if (fetch.rsp_instr !== exp_w) $display("FAIL run_ignore_data: got %h want %h", fetch.rsp_instr, exp_w); else pass_cnt++;
        drain();
    endtask

    task automatic test_reset_mid_response();
        fetch.rsp_ready = 1'b0;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'h10;
        tick();
        fetch.req_valid = 1'b0;
        exp_w = pop_exp();
        total_cnt++;
        if (fetch.rsp_valid !== 1'b1 || fetch.rsp_instr !== exp_w)
            $display("FAIL rstmid_pre: got valid=%b instr=%h want valid=1 instr=%h", fetch.rsp_valid, fetch.rsp_instr, exp_w);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (fetch.rsp_valid !== 1'b0 || loading !== 1'b1) $display("FAIL rstmid_async: got valid=%b loading=%b want valid=0 loading=1", fetch.rsp_valid, loading); else pass_cnt++;
        sb.delete();
        for (int i = 0; i < 256; i++) model_wr[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load_wr = 1'b1; load_done = 1'b1; load_data = 16'h1234;
        model_mem[0] = 16'h1234; model_wr[0] = 1'b1;
        tick();
        load_wr = 1'b0; load_done = 1'b0;
        total_cnt++; if (loading !== 1'b0 || load_ptr !== 8'h01) $display("FAIL wr_with_done: got loading=%b ptr=%h want loading=0 ptr=01", loading, load_ptr); else pass_cnt++;
        fetch.rsp_ready = 1'b1;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'h10;
        tick();
        exp_w = pop_exp();
        total_cnt++; if (fetch.rsp_instr !== 16'h0000 || exp_w !== 16'h0000) $display("FAIL rstmid_cleared: got %h want 0000", fetch.rsp_instr); else pass_cnt++;
        fetch.req_addr = 8'h00;
        tick();
        exp_w = pop_exp();
        total_cnt++; if (fetch.rsp_instr !== exp_w) $display("FAIL rstmid_reload: got %h want %h", fetch.rsp_instr, exp_w); else pass_cnt++;
`ifdef INSTR_MEM_PARITY_EN
        total_cnt++; if (parity_err !== 1'b0) $display("FAIL parity_clean: got %b want 0", parity_err); else pass_cnt++;
        fetch.req_valid = 1'b0;
        tick();
        dut.u_array.mem[0] = dut.u_array.mem[0] ^ 16'h0001;
        fetch.req_valid = 1'b1; fetch.req_addr = 8'h00;
        tick();
        void'(pop_exp());
        total_cnt++; if (fetch.rsp_valid !== 1'b1 || parity_err !== 1'b1) $display("FAIL parity_flip: got valid=%b perr=%b want 1 1", fetch.rsp_valid, parity_err); else pass_cnt++;
`endif
        drain();
        total_cnt++; if (sb.size() != 0) $display("FAIL sb_empty: got %0d entries want 0", sb.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_unwritten();
        test_backpressure();
        test_load_start_drop();
        test_auto_finish();
        test_reset_mid_response();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder: the far end of the fetch stage's address-out/instruction-in interface.
- Holds a 256 x 16 program store, filled by a sequential loader port after reset.
- Serves fetch requests over a valid/ready request/response handshake with 1-cycle read latency.
- Sits between the testbench/boot loader and the fetch stage of the 3-stage pipeline.

Parameters:
- ADDR_W, 8: address width; depth = 2**ADDR_W.
- DATA_W, 16: instruction width.
- NOP_WORD, 16'h0000: value returned for never-written words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  in RUN: return to LOAD, loader pointer cleared to 0.
- load_wr  in  1  write load_data at loader pointer; pointer +1.
- load_data  in  DATA_W  instruction word to store.
- load_done  in  1  end of program load; LOAD -> RUN.
- load_ptr  out  ADDR_W  current loader pointer.
- loading  out  1  high while in LOAD.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_W  fetch address (program counter).
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- rsp_valid  out  1  rsp_instr holds a valid instruction.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_ready  in  1  fetch side consumes the response.

Behaviour:
- Reset (async, any time, including mid-load or mid-response):
  - state=LOAD, load_ptr=0, loading=1.
  - rsp_valid=0, rsp_instr=0, req_ready=0.
  - All per-word written bits cleared. Memory array itself is not reset.
- States: LOAD, RUN.
  - LOAD -> RUN on load_done, or on a load_wr at load_ptr=2**ADDR_W-1 (auto-finish).
  - RUN -> LOAD on load_start; load_ptr <= 0.
- LOAD:
  - load_wr writes mem[load_ptr] <= load_data, sets written[load_ptr], increments load_ptr.
  - Writing the last address wraps load_ptr to 0 and enters RUN.
  - load_wr together with load_done: the write completes first, then enter RUN next cycle.
  - load_start in LOAD: resets load_ptr to 0; state unchanged.
  - req_ready=0 throughout.
- RUN:
  - load_wr and load_done are ignored.
  - req_ready = !rsp_valid || rsp_ready (combinational from state and registers).
  - On req_valid && req_ready: next edge rsp_valid<=1, rsp_instr <= written[req_addr] ? mem[req_addr] : NOP_WORD.
  - Throughput 1 request/cycle when rsp_ready is held high.
  - rsp_valid && !rsp_ready: rsp_instr and rsp_valid hold stable; no new request accepted.
  - rsp_valid && rsp_ready && no new accept: rsp_valid<=0; rsp_instr holds its last value.
  - load_start with a response pending: the response is dropped (rsp_valid<=0 next edge) and no request is accepted that cycle.
- Addresses wrap naturally at ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro INSTR_MEM_PARITY_EN.
- Defined:
  - An extra stored bit per word holds even parity of load_data, written on load_wr.
  - Added output port parity_err (1 bit), valid with rsp_valid: high when the stored parity mismatches the read word.
  - parity_err is 0 for unwritten words; reset value 0.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Shared package pipe_pkg:
  - ADDR_W and DATA_W constants, NOP_WORD.
  - State enum (IMEM_LOAD, IMEM_RUN).
- One natural sub-module, instr_mem_array: storage, written-bit vector, and optional parity bit, with one write port and one registered read port.
- The handshake/FSM stays in the top.

Test Plan:
- Reset, then load_wr x3 with 16'hA001, 16'hB002, 16'hC003, then load_done -> load_ptr=3, loading=0 next cycle.
- RUN, requests for addr 0,1,2 back-to-back with rsp_ready=1 -> rsp_instr A001, B002, C003 on consecutive cycles one cycle later; rsp_valid high for 3 cycles.
- Request addr 8'h50 (never written) -> rsp_instr=16'h0000, rsp_valid=1.
- Response pending with rsp_ready=0 for 4 cycles -> req_ready=0, rsp_instr stable at B002; release -> next request accepted the same cycle.
- 256 consecutive load_wr without load_done -> RUN entered automatically, load_ptr=0; read addr 8'hFF returns the last word.
- rst asserted mid-response (rsp_valid=1) -> rsp_valid=0 and loading=1 immediately; a prior address now reads NOP_WORD after reload/done.
- With INSTR_MEM_PARITY_EN: force-flip a stored bit -> parity_err=1 alongside rsp_valid.
